// File: rtl/fetch_unit_pkg.sv
// ============================================================================
// Module   : fetch_unit_pkg
// Brief    : Shared constants, fault encodings and FSM state type for the
//            RV32 instruction-fetch stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fetch_unit_pkg;

    localparam int              XLEN       = 32;
    localparam logic [XLEN-1:0] RESET_PC   = 32'h0000_0000;
    localparam int              IMEM_BYTES = 512;

    // Highest word address that may legally be fetched.
    localparam logic [XLEN-1:0] C_PC_LAST  = XLEN'(IMEM_BYTES - 4);

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_MISALIGN = 2'd1;
    localparam logic [1:0] FC_RANGE    = 2'd2;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    // Misalignment takes precedence over range when both apply.
    function automatic logic [1:0] fault_check(input logic [XLEN-1:0] pc);
        if (pc[1:0] != 2'b00) begin
            return FC_MISALIGN;
        end else if (pc > C_PC_LAST) begin
            return FC_RANGE;
        end else begin
            return FC_NONE;
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_unit_pc_reg.sv
// ============================================================================
// Module   : fetch_unit_pc_reg
// Brief    : Program counter with next-PC mux (reset / redirect / hold / +4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_unit_pc_reg
    import fetch_unit_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            i_load,
    input  logic [XLEN-1:0] i_target,
    input  logic            i_hold,
    output logic [XLEN-1:0] o_pc
);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;

    always_comb begin
        w_pc_next = r_pc + XLEN'(4);
        if (i_load) begin
            w_pc_next = i_target;
        end else if (i_hold) begin
            w_pc_next = r_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign o_pc = r_pc;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Brief    : RV32 instruction-fetch stage: PC, fault halt FSM, IF/ID register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_data,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc_plus4,
    output logic [31:0]     if_instr,
    output logic            halted,
    output logic [1:0]      fault_cause,
    output logic [31:0]     fetch_count
);

    state_t          r_state;
    state_t          w_state_next;

    logic [XLEN-1:0] w_pc;
    logic [1:0]      w_fc;
    logic            w_run;
    logic            w_redirect;
    logic            w_fault_take;
    logic            w_advance;

    logic            r_if_valid;
    logic [XLEN-1:0] r_if_pc;
    logic [XLEN-1:0] r_if_pc_plus4;
    logic [31:0]     r_if_instr;
    logic [1:0]      r_fault_cause;
    logic [31:0]     r_fetch_count;

    // Cycle priority in RUN: redirect > fault > stall > advance.
    assign w_fc         = fault_check(w_pc);
    assign w_run        = (r_state == ST_RUN);
    assign w_redirect   = w_run & redirect_valid;
    assign w_fault_take = w_run & ~redirect_valid & (w_fc != FC_NONE);
    assign w_advance    = w_run & ~redirect_valid & (w_fc == FC_NONE) & ~stall;

    fetch_unit_pc_reg u_pc_reg (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_redirect),
        .i_target (redirect_target),
        .i_hold   (~w_advance),
        .o_pc     (w_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_fault_take) begin
            w_state_next = ST_HALT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_if_valid    <= 1'b0;
            r_if_pc       <= '0;
            r_if_pc_plus4 <= '0;
            r_if_instr    <= '0;
            r_fault_cause <= FC_NONE;
            r_fetch_count <= '0;
        end else if (w_redirect) begin
            r_if_valid    <= 1'b0;
        end else if (w_fault_take) begin
            r_if_valid    <= 1'b0;
            r_fault_cause <= w_fc;
        end else if (w_advance) begin
            r_if_valid    <= 1'b1;
            r_if_pc       <= w_pc;
            r_if_pc_plus4 <= w_pc + XLEN'(4);
            r_if_instr    <= imem_data;
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign imem_addr   = w_pc;
    assign if_valid    = r_if_valid;
    assign if_pc       = r_if_pc;
    assign if_pc_plus4 = r_if_pc_plus4;
    assign if_instr    = r_if_instr;
    assign halted      = (r_state == ST_HALT);
    assign fault_cause = r_fault_cause;
    assign fetch_count = r_fetch_count;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Directed self-checking bench for fetch_unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [31:0] if_instr;
    logic        halted;
    logic [1:0]  fault_cause;
    logic [31:0] fetch_count;

    int n_vec;
    int n_err;

    fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .if_valid        (if_valid),
        .if_pc           (if_pc),
        .if_pc_plus4     (if_pc_plus4),
        .if_instr        (if_instr),
        .halted          (halted),
        .fault_cause     (fault_cause),
        .fetch_count     (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word index 3 is all-zero to confirm zero words still issue as valid.
    function automatic logic [31:0] word_at(input logic [31:0] addr);
        logic [31:0] idx;
        idx = addr >> 2;
        if (idx == 32'd3) return 32'h0000_0000;
        return {16'hC0DE, idx[15:0]};
    endfunction

    always_comb begin
        if (imem_addr[1:0] == 2'b00 && imem_addr < 32'd512) imem_data = word_at(imem_addr);
        else imem_data = 32'hFFFF_FFFF;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic run_until(input logic [31:0] addr);
        int k;
        k = 0;
        while (imem_addr !== addr && k < 300) begin
            tick();
            k++;
        end
        n_vec++;
        if (imem_addr !== addr) begin
            n_err++;
            $display("FAIL run_until: got %h expected %h", imem_addr, addr);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        tick();
        tick();
        if (imem_addr !== 32'd0)  begin n_err++; $display("FAIL reset_pc: got %h expected %h", imem_addr, 32'd0); end
        n_vec++;
        if (if_valid !== 1'b0)    begin n_err++; $display("FAIL reset_valid: got %b expected 0", if_valid); end
        n_vec++;
        if (if_pc !== 32'd0 || if_pc_plus4 !== 32'd0 || if_instr !== 32'd0) begin
            n_err++; $display("FAIL reset_ifid: got pc %h pc4 %h instr %h expected zeros", if_pc, if_pc_plus4, if_instr);
        end
        n_vec++;
        if (halted !== 1'b0 || fault_cause !== 2'd0 || fetch_count !== 32'd0) begin
            n_err++; $display("FAIL reset_status: got halted %b cause %0d count %0d expected 0 0 0", halted, fault_cause, fetch_count);
        end
        n_vec++;
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("seq_addr",  imem_addr,   32'(4 * k));
            chk("seq_valid", {31'd0, if_valid}, 32'd1);
            chk("seq_pc",    if_pc,       32'(4 * (k - 1)));
            chk("seq_pc4",   if_pc_plus4, 32'(4 * k));
            chk("seq_instr", if_instr,    word_at(32'(4 * (k - 1))));
            chk("seq_count", fetch_count, 32'(k));
        end
    endtask

    task automatic test_redirect();
        run_until(32'd36);
        chk("redir_precount", fetch_count, 32'd9);
        redirect_valid = 1'b1; redirect_target = 32'd44;
        tick();
        redirect_valid = 1'b0;
        chk("redir_bubble", {31'd0, if_valid}, 32'd0);
        chk("redir_addr",   imem_addr,   32'd44);
        chk("redir_count",  fetch_count, 32'd9);
        tick();
        chk("redir_valid",  {31'd0, if_valid}, 32'd1);
        chk("redir_pc",     if_pc,       32'd44);
        chk("redir_pc4",    if_pc_plus4, 32'd48);
        chk("redir_instr",  if_instr,    word_at(32'd44));
        chk("redir_next",   imem_addr,   32'd48);
    endtask

    task automatic test_stall();
        do_reset();
        run_until(32'd16);
        chk("stall_precount", fetch_count, 32'd4);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_addr",  imem_addr,   32'd16);
            chk("stall_pc",    if_pc,       32'd12);
            chk("stall_instr", if_instr,    32'd0);
            chk("stall_valid", {31'd0, if_valid}, 32'd1);
            chk("stall_count", fetch_count, 32'd4);
        end
        stall = 1'b0;
        tick();
        chk("stall_rel_addr",  imem_addr,   32'd20);
        chk("stall_rel_pc",    if_pc,       32'd16);
        chk("stall_rel_count", fetch_count, 32'd5);
    endtask

    task automatic test_stall_redirect();
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'd56;
        tick();
        redirect_valid = 1'b0;
        chk("sr_addr",  imem_addr, 32'd56);
        chk("sr_valid", {31'd0, if_valid}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("sr_hold_addr",  imem_addr, 32'd56);
            chk("sr_hold_valid", {31'd0, if_valid}, 32'd0);
            chk("sr_hold_count", fetch_count, 32'd5);
        end
        stall = 1'b0;
        tick();
        chk("sr_rel_pc",    if_pc, 32'd56);
        chk("sr_rel_valid", {31'd0, if_valid}, 32'd1);
    endtask

    task automatic test_misalign();
        redirect_valid = 1'b1; redirect_target = 32'h0000_002A;
        tick();
        redirect_valid = 1'b0;
        chk("mis_addr",    imem_addr, 32'h2A);
        chk("mis_nohalt",  {31'd0, halted}, 32'd0);
        tick();
        chk("mis_halted",  {31'd0, halted}, 32'd1);
        chk("mis_cause",   {30'd0, fault_cause}, 32'd1);
        chk("mis_valid",   {31'd0, if_valid}, 32'd0);
        chk("mis_hold",    imem_addr, 32'h2A);
        redirect_valid = 1'b1; redirect_target = 32'd8;
        tick();
        tick();
        redirect_valid = 1'b0;
        chk("mis_ignore",  imem_addr, 32'h2A);
        chk("mis_still",   {31'd0, halted}, 32'd1);
        chk("mis_count",   fetch_count, 32'd6);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mis_rst_pc",    imem_addr, 32'd0);
        chk("mis_rst_halt",  {31'd0, halted}, 32'd0);
        chk("mis_rst_cause", {30'd0, fault_cause}, 32'd0);
        chk("mis_rst_count", fetch_count, 32'd0);
    endtask

    task automatic test_range();
        redirect_valid = 1'b1; redirect_target = 32'd480;
        tick();
        redirect_valid = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        chk("rng_last_pc",    if_pc,     32'd508);
        chk("rng_last_valid", {31'd0, if_valid}, 32'd1);
        chk("rng_last_instr", if_instr,  word_at(32'd508));
        chk("rng_addr",       imem_addr, 32'd512);
        chk("rng_nohalt",     {31'd0, halted}, 32'd0);
        tick();
        chk("rng_halted",     {31'd0, halted}, 32'd1);
        chk("rng_cause",      {30'd0, fault_cause}, 32'd2);
        chk("rng_valid",      {31'd0, if_valid}, 32'd0);
        tick();
        chk("rng_hold_addr",  imem_addr, 32'd512);
        chk("rng_hold_pc",    if_pc,     32'd508);
        chk("rng_count",      fetch_count, 32'd8);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        test_reset();
        test_sequential();
        test_redirect();
        test_stall();
        test_stall_redirect();
        test_misalign();
        test_range();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
